// File: rtl/s27_resp_compactor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : s27_resp_compactor_if                                  |
// | Description : Control, sample and status bundle for the s27 response |
// |               compactor.                                              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface s27_resp_compactor_if;
    logic        start;
    logic        abort;
    logic        G17;
    logic        G17_valid;
    logic [15:0] expected;
    logic        busy;
    logic        done;
    logic        pass;
    logic        fail;
    logic [15:0] signature;
    logic [15:0] sample_cnt;

    // Driver side: issues commands and samples, observes status.
    modport master (
        output start, abort, G17, G17_valid, expected,
        input  busy, done, pass, fail, signature, sample_cnt
    );

    // Compactor side.
    modport slave (
        input  start, abort, G17, G17_valid, expected,
        output busy, done, pass, fail, signature, sample_cnt
    );
endinterface
`default_nettype wire

// File: rtl/s27_resp_compactor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : s27_resp_compactor                                     |
// | Description : Compacts a window of valid G17 samples into a 16-bit    |
// |               SISR and compares the result to a golden signature.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module s27_resp_compactor #(
    parameter int          WINDOW = 16,
    parameter logic [15:0] POLY   = 16'h1021,
    parameter logic [15:0] SEED   = 16'h0000
) (
    input  wire                    clk,
    input  wire                    reset,
    s27_resp_compactor_if.slave    bus
);

    localparam logic [15:0] c_LAST_IDX = 16'(WINDOW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_sig;
    logic [15:0] r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;

    logic [15:0] w_sig_next;
    logic        w_match;
    logic        w_last;

    // One SISR step: shift left, fold the MSB back through the taps, inject G17.
    assign w_sig_next = {r_sig[14:0], 1'b0}
                      ^ (r_sig[15] ? POLY : 16'h0000)
                      ^ {15'b0, bus.G17};
    // Verdict uses the signature that the final sample produces, not the current one.
    assign w_match    = (w_sig_next == bus.expected);
    assign w_last     = (r_cnt == c_LAST_IDX);

    // Run-control FSM with registered status flags; abort outranks start and samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sig   <= 16'h0000;
            r_cnt   <= 16'h0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_sig   <= SEED;
                        r_cnt   <= 16'h0000;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (bus.G17_valid) begin
                        r_sig <= w_sig_next;
                        r_cnt <= r_cnt + 16'd1;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= w_match;
                            r_fail  <= ~w_match;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b0;
                    end else if (bus.start) begin
                        r_state <= S_RUN;
                        r_sig   <= SEED;
                        r_cnt   <= 16'h0000;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                    r_fail  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.fail       = r_fail;
    assign bus.signature  = r_sig;
    assign bus.sample_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_s27_resp_compactor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_s27_resp_compactor                                  |
// | Description : Three compactors (WINDOW 4/17/1) driven by one shared   |
// |               stimulus stream; directed vectors plus random traffic   |
// |               checked against a behavioural model.                    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_s27_resp_compactor;

    localparam logic [15:0] c_POLY = 16'h1021;
    localparam int          c_N    = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic        d_start = 1'b0;
    logic        d_abort = 1'b0;
    logic        d_g17   = 1'b0;
    logic        d_valid = 1'b0;
    logic [15:0] d_exp   = 16'h0000;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    s27_resp_compactor_if if0 ();
    s27_resp_compactor_if if1 ();
    s27_resp_compactor_if if2 ();

    assign if0.start = d_start;  assign if0.abort = d_abort;  assign if0.G17 = d_g17;
    assign if0.G17_valid = d_valid;  assign if0.expected = d_exp;
    assign if1.start = d_start;  assign if1.abort = d_abort;  assign if1.G17 = d_g17;
    assign if1.G17_valid = d_valid;  assign if1.expected = d_exp;
    assign if2.start = d_start;  assign if2.abort = d_abort;  assign if2.G17 = d_g17;
    assign if2.G17_valid = d_valid;  assign if2.expected = d_exp;

    s27_resp_compactor #(.WINDOW(4),  .POLY(c_POLY), .SEED(16'h0000)) u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    s27_resp_compactor #(.WINDOW(17), .POLY(c_POLY), .SEED(16'h0000)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    s27_resp_compactor #(.WINDOW(1),  .POLY(c_POLY), .SEED(16'hACE1)) u_dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    // Observed status word per DUT: {busy, done, pass, fail, signature, sample_cnt}.
    logic [35:0] w_obs [c_N];
    assign w_obs[0] = {if0.busy, if0.done, if0.pass, if0.fail, if0.signature, if0.sample_cnt};
    assign w_obs[1] = {if1.busy, if1.done, if1.pass, if1.fail, if1.signature, if1.sample_cnt};
    assign w_obs[2] = {if2.busy, if2.done, if2.pass, if2.fail, if2.signature, if2.sample_cnt};

    // ---------------- behavioural model ----------------
    int          c_win  [c_N] = '{4, 17, 1};
    logic [15:0] c_seed [c_N] = '{16'h0000, 16'h0000, 16'hACE1};
    bit          m_run  [c_N];
    bit          m_fin  [c_N];
    bit          m_pass [c_N];
    logic [15:0] m_sig  [c_N];
    int          m_cnt  [c_N];

    function automatic logic [15:0] sisr(input logic [15:0] s, input logic b);
        logic [15:0] r;
        r = s << 1;
        if (s[15]) r = r ^ c_POLY;
        r[0] = r[0] ^ b;
        return r;
    endfunction

    task automatic model_cycle(input logic rs, input logic st, input logic ab,
                               input logic g, input logic v, input logic [15:0] ex);
        for (int k = 0; k < c_N; k++) begin
            if (rs) begin
                m_run[k] = 0; m_fin[k] = 0; m_pass[k] = 0; m_sig[k] = 16'h0000; m_cnt[k] = 0;
            end else if (m_run[k]) begin
                if (ab) m_run[k] = 0;
                else if (v) begin
                    m_sig[k] = sisr(m_sig[k], g);
                    m_cnt[k] = m_cnt[k] + 1;
                    if (m_cnt[k] == c_win[k]) begin
                        m_run[k] = 0; m_fin[k] = 1; m_pass[k] = (m_sig[k] == ex);
                    end
                end
            end else if (ab && m_fin[k]) begin
                m_fin[k] = 0; m_pass[k] = 0;
            end else if (st) begin
                m_run[k] = 1; m_fin[k] = 0; m_pass[k] = 0; m_sig[k] = c_seed[k]; m_cnt[k] = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [35:0] exp_w;
        for (int k = 0; k < c_N; k++) begin
            exp_w = {m_run[k], m_fin[k], m_fin[k] & m_pass[k], m_fin[k] & ~m_pass[k],
                     m_sig[k], 16'(m_cnt[k])};
            checks++;
            if (w_obs[k] !== exp_w) begin
                errors++;
                $display("FAIL %s dut%0d: got b/d/p/f=%b sig=%h cnt=%0d, want b/d/p/f=%b sig=%h cnt=%0d",
                         tag, k, w_obs[k][35:32], w_obs[k][31:16], w_obs[k][15:0],
                         exp_w[35:32], exp_w[31:16], exp_w[15:0]);
            end
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later, check all DUTs.
    task automatic cycle(input logic rs, input logic st, input logic ab,
                         input logic g, input logic v, input logic [15:0] ex, input string tag);
        reset = rs; d_start = st; d_abort = ab; d_g17 = g; d_valid = v; d_exp = ex;
        @(posedge clk);
        #1;
        model_cycle(rs, st, ab, g, v, ex);
        check_model(tag);
    endtask

    task automatic check_one(input string tag, input logic [35:0] got, input logic [35:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got b/d/p/f=%b sig=%h cnt=%0d, want b/d/p/f=%b sig=%h cnt=%0d",
                     tag, got[35:32], got[31:16], got[15:0], want[35:32], want[31:16], want[15:0]);
        end
    endtask

    // ---------------- directed vector table (checked on the WINDOW=4 DUT) ----------------
    typedef struct packed {
        logic        st, ab, g, v;
        logic [15:0] ex;
        logic        busy, done, pass, fail;
        logic [15:0] sig, cnt;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic st, ab, g, v, input logic [15:0] ex,
                                input logic [3:0] flags, input logic [15:0] sig, cnt);
        vec_t r;
        r.st = st; r.ab = ab; r.g = g; r.v = v; r.ex = ex;
        {r.busy, r.done, r.pass, r.fail} = flags;
        r.sig = sig; r.cnt = cnt;
        return r;
    endfunction

    initial begin
        logic        rs, st, ab, g, v;
        logic [15:0] ex;
        int          j;

        // T2: single-bit shift, WINDOW=4, pass on 0x0008
        tbl[0]  = mk(1,0,0,0,16'h0000, 4'b1000, 16'h0000, 16'd0);
        tbl[1]  = mk(0,0,1,1,16'h0000, 4'b1000, 16'h0001, 16'd1);
        tbl[2]  = mk(0,0,0,1,16'h0000, 4'b1000, 16'h0002, 16'd2);
        tbl[3]  = mk(0,0,0,1,16'h0000, 4'b1000, 16'h0004, 16'd3);
        tbl[4]  = mk(0,0,0,1,16'h0008, 4'b0110, 16'h0008, 16'd4);
        tbl[5]  = mk(0,0,1,1,16'h0000, 4'b0110, 16'h0008, 16'd4);
        // T6 + T4: restart from DONE, then gapped valid with the same bit pattern
        tbl[6]  = mk(1,0,0,0,16'h0000, 4'b1000, 16'h0000, 16'd0);
        tbl[7]  = mk(0,0,1,1,16'h0000, 4'b1000, 16'h0001, 16'd1);
        tbl[8]  = mk(0,0,0,0,16'h0000, 4'b1000, 16'h0001, 16'd1);
        tbl[9]  = mk(0,0,0,1,16'h0000, 4'b1000, 16'h0002, 16'd2);
        tbl[10] = mk(0,0,1,0,16'h0000, 4'b1000, 16'h0002, 16'd2);
        tbl[11] = mk(0,0,0,1,16'h0000, 4'b1000, 16'h0004, 16'd3);
        tbl[12] = mk(0,0,0,0,16'h0000, 4'b1000, 16'h0004, 16'd3);
        tbl[13] = mk(0,0,0,1,16'h0008, 4'b0110, 16'h0008, 16'd4);
        // T5: start+abort in DONE, abort after 2 samples, start ignored in RUN
        tbl[14] = mk(1,1,0,0,16'h0000, 4'b0000, 16'h0008, 16'd4);
        tbl[15] = mk(1,0,0,0,16'h0000, 4'b1000, 16'h0000, 16'd0);
        tbl[16] = mk(0,0,1,1,16'h0000, 4'b1000, 16'h0001, 16'd1);
        tbl[17] = mk(0,0,1,1,16'h0000, 4'b1000, 16'h0003, 16'd2);
        tbl[18] = mk(1,0,0,0,16'h0000, 4'b1000, 16'h0003, 16'd2);
        tbl[19] = mk(0,1,1,1,16'h0000, 4'b0000, 16'h0003, 16'd2);
        tbl[20] = mk(0,0,1,1,16'h0000, 4'b0000, 16'h0003, 16'd2);

        // Reset state
        cycle(1,0,0,0,0,16'h0000, "reset");
        cycle(1,0,0,1,1,16'h0000, "reset");
        check_one("reset_state", w_obs[0], 36'h0);

        for (int i = 0; i < 21; i++) begin
            cycle(0, tbl[i].st, tbl[i].ab, tbl[i].g, tbl[i].v, tbl[i].ex, $sformatf("vec%0d", i));
            check_one($sformatf("tbl%0d", i), w_obs[0],
                      {tbl[i].busy, tbl[i].done, tbl[i].pass, tbl[i].fail, tbl[i].sig, tbl[i].cnt});
        end

        // T3: feedback path on the WINDOW=17 DUT, mismatch against 0x1020
        cycle(1,0,0,0,0,16'h1020, "t3_rst");
        cycle(0,1,0,0,0,16'h1020, "t3_start");
        cycle(0,0,0,1,1,16'h1020, "t3_s");
        for (int i = 0; i < 16; i++) cycle(0,0,0,0,1,16'h1020, "t3_s");
        check_one("t3_feedback_fail", w_obs[1], {4'b0101, 16'h1021, 16'd17});

        // T1: reset in the middle of a run after 5 samples
        cycle(0,1,1,0,0,16'h0000, "t1_abort");
        cycle(0,1,0,0,0,16'h0000, "t1_start");
        for (int i = 0; i < 5; i++) cycle(0,0,0,1,1,16'h0000, "t1_s");
        cycle(1,0,0,1,1,16'h0000, "t1_rst");
        check_one("t1_reset_midrun", w_obs[1], 36'h0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 5) == 0);
            ab = ($urandom_range(0, 29) == 0);
            g  = 1'($urandom_range(0, 1));
            v  = ($urandom_range(0, 2) != 0);
            j  = $urandom_range(0, c_N - 1);
            ex = ($urandom_range(0, 1) == 1) ? sisr(m_sig[j], g) : 16'($urandom);
            cycle(rs, st, ab, g, v, ex, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
